// File: rtl/uart_tx_packer_pkg.sv
// Shared constants, FSM state type and frame builders for the UART TX frame packer.
package uart_tx_packer_pkg;

  localparam logic [7:0] ADS_HDR     = 8'hAA;
  localparam logic [7:0] MPR_HDR     = 8'hBB;
  localparam logic [7:0] ADS_REG_HDR = 8'h61;
  localparam logic [7:0] MPR_REG_HDR = 8'h6D;

  localparam int unsigned ADS_W   = 48;
  localparam int unsigned MPR_W   = 16;
  localparam int unsigned REG_W   = 17;
  localparam int unsigned FRAME_W = 56;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_ARMED = 2'd2
  } tx_state_t;

  function automatic logic [FRAME_W-1:0] ads_frame(input logic [ADS_W-1:0] d);
    return {ADS_HDR, d};
  endfunction

  // 24-bit frames repeat the header at [31:24], where the controller dispatches.
  function automatic logic [FRAME_W-1:0] mpr_frame(input logic [MPR_W-1:0] m);
    return {MPR_HDR, m, MPR_HDR, 24'h0};
  endfunction

  function automatic logic [FRAME_W-1:0] reg_frame(input logic [REG_W-1:0] r);
    logic [7:0] hdr;
    hdr = r[16] ? MPR_REG_HDR : ADS_REG_HDR;
    return {hdr, r[15:8], r[7:0], hdr, 24'h0};
  endfunction

endpackage

// File: rtl/uart_tx_packer_slot.sv
// One pending-item holding slot: newest-wins overwrite, clear on load, optional saturating drop counter.
module uart_tx_packer_slot #(
  parameter int unsigned W      = 8,
  parameter bit          CNT_EN = 1'b0
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] data,
  output logic [7:0]   drop_cnt
);

  // A write in the same cycle as the load keeps the new item and is not a drop.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      full     <= 1'b0;
      data     <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr) begin
        data <= wr_data;
        full <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
      if (CNT_EN && wr && full && !clr && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/uart_tx_packer.sv
// Frame builder ahead of the UART controller TX path: three slots, fixed-priority arbitration, valid/ready offer FSM.
module uart_tx_packer
  import uart_tx_packer_pkg::*;
(
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic [47:0]  i_ADS_DATA,
  input  logic         i_ADS_DATA_VALID,
  input  logic [15:0]  i_MPR_DATA,
  input  logic         i_MPR_DATA_VALID,
  input  logic [7:0]   i_REG_ADDR,
  input  logic [7:0]   i_REG_DATA,
  input  logic         i_REG_SRC,
  input  logic         i_REG_DATA_VALID,
  output logic [55:0]  o_UART_DATA_TX,
  output logic         o_UART_DATA_TX_VALID,
  input  logic         i_UART_DATA_TX_READY,
  output logic [7:0]   o_ADS_DROP_CNT,
  output logic [7:0]   o_MPR_DROP_CNT,
  output logic         o_BUSY
);

  tx_state_t state, state_nxt;

  logic             reg_full, ads_full, mpr_full;
  logic             reg_clr, ads_clr, mpr_clr;
  logic [REG_W-1:0] reg_q;
  logic [ADS_W-1:0] ads_q;
  logic [MPR_W-1:0] mpr_q;
  logic [7:0]       reg_drop_unused;
  logic [FRAME_W-1:0] frame_nxt;
  logic             load;

  uart_tx_packer_slot #(.W(REG_W), .CNT_EN(1'b0)) u_reg_slot (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .wr(i_REG_DATA_VALID), .wr_data({i_REG_SRC, i_REG_ADDR, i_REG_DATA}),
    .clr(reg_clr), .full(reg_full), .data(reg_q), .drop_cnt(reg_drop_unused)
  );

  uart_tx_packer_slot #(.W(ADS_W), .CNT_EN(1'b1)) u_ads_slot (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .wr(i_ADS_DATA_VALID), .wr_data(i_ADS_DATA),
    .clr(ads_clr), .full(ads_full), .data(ads_q), .drop_cnt(o_ADS_DROP_CNT)
  );

  uart_tx_packer_slot #(.W(MPR_W), .CNT_EN(1'b1)) u_mpr_slot (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .wr(i_MPR_DATA_VALID), .wr_data(i_MPR_DATA),
    .clr(mpr_clr), .full(mpr_full), .data(mpr_q), .drop_cnt(o_MPR_DROP_CNT)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (reg_full || ads_full || mpr_full) state_nxt = S_OFFER;
      S_OFFER: if (i_UART_DATA_TX_READY)             state_nxt = S_ARMED;
      S_ARMED: if (!i_UART_DATA_TX_READY)            state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fixed priority REG > ADS > MPR; only the winning slot is cleared on load.
  always_comb begin
    reg_clr   = 1'b0;
    ads_clr   = 1'b0;
    mpr_clr   = 1'b0;
    frame_nxt = '0;
    load      = 1'b0;
    o_UART_DATA_TX_VALID = (state != S_IDLE);
    if (state == S_IDLE) begin
      if (reg_full) begin
        reg_clr   = 1'b1;
        load      = 1'b1;
        frame_nxt = reg_frame(reg_q);
      end else if (ads_full) begin
        ads_clr   = 1'b1;
        load      = 1'b1;
        frame_nxt = ads_frame(ads_q);
      end else if (mpr_full) begin
        mpr_clr   = 1'b1;
        load      = 1'b1;
        frame_nxt = mpr_frame(mpr_q);
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)     o_UART_DATA_TX <= '0;
    else if (load) o_UART_DATA_TX <= frame_nxt;
  end

  assign o_BUSY = reg_full || ads_full || mpr_full || (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_packer.sv
// Directed, table-driven bench for uart_tx_packer with hand-computed frames.
module tb_uart_tx_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ads_data;
  logic        ads_valid;
  logic [15:0] mpr_data;
  logic        mpr_valid;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_src;
  logic        reg_valid;
  logic [55:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  ads_drop;
  logic [7:0]  mpr_drop;
  logic        busy;

  int total = 0;
  int bad   = 0;

  uart_tx_packer dut (
    .i_CLK(clk), .i_RST(rst),
    .i_ADS_DATA(ads_data), .i_ADS_DATA_VALID(ads_valid),
    .i_MPR_DATA(mpr_data), .i_MPR_DATA_VALID(mpr_valid),
    .i_REG_ADDR(reg_addr), .i_REG_DATA(reg_data), .i_REG_SRC(reg_src),
    .i_REG_DATA_VALID(reg_valid),
    .o_UART_DATA_TX(tx_data), .o_UART_DATA_TX_VALID(tx_valid),
    .i_UART_DATA_TX_READY(tx_ready),
    .o_ADS_DROP_CNT(ads_drop), .o_MPR_DROP_CNT(mpr_drop), .o_BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = ADS, 1 = MPR, 2 = REG
    logic [47:0] ads;
    logic [15:0] mpr;
    logic        src;
    logic [7:0]  addr;
    logic [7:0]  rdata;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic clear_strobes();
    ads_valid = 1'b0;
    mpr_valid = 1'b0;
    reg_valid = 1'b0;
  endtask

  // Offered frame in S_OFFER: ready high one cycle, then low; valid must fall after that.
  task automatic accept(input string name);
    tx_ready = 1'b1;
    tick();
    chk({name, "_armed_valid"}, 64'(tx_valid), 64'd1);
    tx_ready = 1'b0;
    tick();
    chk({name, "_drop_valid"}, 64'(tx_valid), 64'd0);
  endtask

  initial begin
    int rises;
    logic prev;

    vecs[0] = '{0, 48'h123456_ABCDEF, 16'h0, 1'b0, 8'h00, 8'h00, 56'hAA123456ABCDEF};
    vecs[1] = '{1, 48'h0, 16'h0A05, 1'b0, 8'h00, 8'h00, 56'hBB0A05BB000000};
    vecs[2] = '{2, 48'h0, 16'h0, 1'b1, 8'h5C, 8'h10, 56'h6D5C106D000000};
    vecs[3] = '{2, 48'h0, 16'h0, 1'b0, 8'h21, 8'hF3, 56'h6121F361000000};
    vecs[4] = '{0, 48'hFFFFFF_000001, 16'h0, 1'b0, 8'h00, 8'h00, 56'hAAFFFFFF000001};
    vecs[5] = '{1, 48'h0, 16'hFFFF, 1'b0, 8'h00, 8'h00, 56'hBBFFFFBB000000};

    rst = 1'b1; tx_ready = 1'b0;
    ads_data = '0; mpr_data = '0; reg_addr = '0; reg_data = '0; reg_src = 1'b0;
    clear_strobes();
    repeat (2) tick();
    chk("rst_data",  64'(tx_data),  64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_adsc",  64'(ads_drop), 64'd0);
    chk("rst_mprc",  64'(mpr_drop), 64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    rst = 1'b0;
    tick();

    // ADS sample with ready held high: valid in cycle 2, drops 1 cycle after ready goes low.
    tx_ready = 1'b1;
    ads_data = 48'h123456_ABCDEF; ads_valid = 1'b1;
    tick();
    clear_strobes();
    chk("lat_c1_valid", 64'(tx_valid), 64'd0);
    chk("lat_c1_busy",  64'(busy),     64'd1);
    tick();
    chk("lat_c2_valid", 64'(tx_valid), 64'd1);
    chk("lat_c2_frame", 64'(tx_data),  64'(56'hAA123456ABCDEF));
    tick();
    chk("lat_c3_valid", 64'(tx_valid), 64'd1);
    tx_ready = 1'b0;
    tick();
    chk("lat_c4_valid", 64'(tx_valid), 64'd0);
    chk("lat_c4_busy",  64'(busy),     64'd0);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0: begin ads_data = vecs[i].ads; ads_valid = 1'b1; end
        1: begin mpr_data = vecs[i].mpr; mpr_valid = 1'b1; end
        default: begin
          reg_src = vecs[i].src; reg_addr = vecs[i].addr; reg_data = vecs[i].rdata;
          reg_valid = 1'b1;
        end
      endcase
      tick();
      clear_strobes();
      chk($sformatf("vec%0d_c1_valid", i), 64'(tx_valid), 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(tx_valid), 64'd1);
      chk($sformatf("vec%0d_frame", i), 64'(tx_data), 64'(vecs[i].exp));
      accept($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // Simultaneous strobes: REG, then ADS, then MPR; each next frame after one idle cycle.
    ads_data = 48'h010203_040506; ads_valid = 1'b1;
    mpr_data = 16'h7788;          mpr_valid = 1'b1;
    reg_src = 1'b0; reg_addr = 8'h01; reg_data = 8'h02; reg_valid = 1'b1;
    tick();
    clear_strobes();
    tick();
    chk("sim_reg_frame", 64'(tx_data), 64'(56'h61010261000000));
    accept("sim_reg");
    tick();
    chk("sim_ads_valid", 64'(tx_valid), 64'd1);
    chk("sim_ads_frame", 64'(tx_data),  64'(56'hAA010203040506));
    accept("sim_ads");
    tick();
    chk("sim_mpr_frame", 64'(tx_data),  64'(56'hBB7788BB000000));
    accept("sim_mpr");
    chk("sim_adsc", 64'(ads_drop), 64'd0);
    chk("sim_mprc", 64'(mpr_drop), 64'd0);
    chk("sim_busy", 64'(busy),     64'd0);

    // Strobe in the load cycle: old sample sent, new one kept, no drop.
    ads_data = 48'hAAAAAA_111111; ads_valid = 1'b1;
    tick();
    ads_data = 48'hBBBBBB_222222;
    tick();
    clear_strobes();
    chk("coll_old_frame", 64'(tx_data),  64'(56'hAAAAAAAA111111));
    chk("coll_adsc",      64'(ads_drop), 64'd0);
    accept("coll_old");
    tick();
    chk("coll_new_frame", 64'(tx_data),  64'(56'hAABBBBBB222222));
    accept("coll_new");

    // 300 ADS strobes while an MPR frame waits with ready low.
    mpr_data = 16'h1234; mpr_valid = 1'b1;
    tick();
    clear_strobes();
    tick();
    chk("sat_mpr_frame", 64'(tx_data), 64'(56'hBB1234BB000000));
    for (int i = 0; i < 300; i++) begin
      ads_data = (i == 299) ? 48'hFEDCBA_987654 : 48'(i);
      ads_valid = 1'b1;
      tick();
      if (i == 9) chk("sat_adsc_9", 64'(ads_drop), 64'd9);
    end
    clear_strobes();
    chk("sat_adsc",      64'(ads_drop), 64'hFF);
    chk("sat_hold_valid", 64'(tx_valid), 64'd1);
    chk("sat_hold_frame", 64'(tx_data), 64'(56'hBB1234BB000000));
    accept("sat_mpr");
    tick();
    chk("sat_ads_frame", 64'(tx_data), 64'(56'hAAFEDCBA987654));
    for (int i = 1; i <= 3; i++) begin
      mpr_data = 16'(i); mpr_valid = 1'b1;
      tick();
    end
    clear_strobes();
    chk("mprc_2", 64'(mpr_drop), 64'd2);
    accept("sat_ads");
    tick();
    chk("mpr_last_frame", 64'(tx_data), 64'(56'hBB0003BB000000));

    // Ready held high in S_ARMED for 3 cycles, then dropped: one acceptance only.
    tx_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rx_hold%0d_valid", i), 64'(tx_valid), 64'd1);
    end
    tx_ready = 1'b0;
    tick();
    chk("rx_drop_valid", 64'(tx_valid), 64'd0);
    rises = 0; prev = tx_valid;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_valid && !prev) rises++;
      prev = tx_valid;
    end
    chk("rx_no_dup", 64'(rises), 64'd0);
    chk("rx_adsc_kept", 64'(ads_drop), 64'hFF);

    // Reset while offering with every slot full.
    ads_data = 48'h0F0F0F_0F0F0F; ads_valid = 1'b1;
    tick();
    clear_strobes();
    tick();
    chk("rstm_valid_pre", 64'(tx_valid), 64'd1);
    ads_valid = 1'b1; mpr_valid = 1'b1; reg_valid = 1'b1;
    tick();
    clear_strobes();
    chk("rstm_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("rstm_data",  64'(tx_data),  64'd0);
    chk("rstm_valid", 64'(tx_valid), 64'd0);
    chk("rstm_adsc",  64'(ads_drop), 64'd0);
    chk("rstm_mprc",  64'(mpr_drop), 64'd0);
    chk("rstm_busy",  64'(busy),     64'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_valid) rises++;
    end
    chk("rstm_no_frame", 64'(rises), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
